// File: rtl/hazard_forward_tracker.sv
// Tracks in-flight destinations and forwards live stage results to operand reads; reads are combinational, entries shift each non-held cycle.
// Pending operands drop issue_ready. Optional stall counter behind FORWARD_STALL_COUNTER_EN.
module hazard_forward_tracker #(
  parameter int XLEN       = 32,
  parameter int STAGES     = 3,
  parameter int READ_PORTS = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [4:0]                   issue_rd,
  input  logic                         issue_rd_enable,
  input  logic                         hold,
  input  logic                         flush,
  input  logic [STAGES-1:0]            stage_result_valid,
  input  logic [STAGES*XLEN-1:0]       stage_result,
  input  logic [READ_PORTS-1:0]        read_enable,
  input  logic [READ_PORTS*5-1:0]      read_number,
  input  logic [READ_PORTS*XLEN-1:0]   read_value,
  output logic [READ_PORTS*XLEN-1:0]   read_result,
  output logic [READ_PORTS-1:0]        read_pending,
  output logic [31:0]                  stall_count
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_has;
  logic [4:0]        r_rd    [STAGES];
  logic [XLEN-1:0]   r_value [STAGES];

  logic [STAGES-1:0] w_live_has;
  logic [XLEN-1:0]   w_live_value [STAGES];
  logic              w_hazard;

  // A result arriving at an invalid entry is dropped.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      w_live_has[i]   = r_has[i] | (r_valid[i] & stage_result_valid[i]);
      w_live_value[i] = (r_valid[i] & stage_result_valid[i]) ?
                        stage_result[i*XLEN +: XLEN] : r_value[i];
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    read_result  = read_value;
    read_pending = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (r_valid[i] && (r_rd[i] == read_number[p*5 +: 5]) && (r_rd[i] != 5'd0)) begin
          read_result[p*XLEN +: XLEN] = w_live_value[i];
          read_pending[p]             = read_enable[p] & ~w_live_has[i];
        end
      end
    end
    w_hazard    = |read_pending;
    issue_ready = ~w_hazard & ~hold & ~flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_has   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_rd[i]    <= 5'd0;
        r_value[i] <= '0;
      end
    end else if (hold) begin
      for (int i = 0; i < STAGES; i++) begin
        r_has[i]   <= w_live_has[i];
        r_value[i] <= w_live_value[i];
      end
      if (flush) r_valid[0] <= 1'b0;
    end else begin
      r_valid[0] <= issue_valid & issue_ready & issue_rd_enable & (issue_rd != 5'd0);
      r_rd[0]    <= issue_rd;
      r_has[0]   <= 1'b0;
      r_value[0] <= '0;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1] & ~(flush && (i == 1));
        r_rd[i]    <= r_rd[i-1];
        r_has[i]   <= w_live_has[i-1];
        r_value[i] <= w_live_value[i-1];
      end
    end
  end

`ifdef FORWARD_STALL_COUNTER_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= 32'd0;
    end else if (issue_valid && w_hazard && !hold && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_tracker.sv
// Scoreboard bench for hazard_forward_tracker: expectations queued as stimulus is applied, checked mid-cycle.
module tb_hazard_forward_tracker;
  localparam int XLEN = 32;
  localparam int STAGES = 3;
  localparam int RP = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 issue_valid, issue_ready, issue_rd_enable, hold, flush;
  logic [4:0]           issue_rd;
  logic [STAGES-1:0]    srv;
  logic [STAGES*XLEN-1:0] stage_result;
  logic [RP-1:0]        read_enable, read_pending;
  logic [RP*5-1:0]      read_number;
  logic [RP*XLEN-1:0]   read_value, read_result;
  logic [31:0]          stall_count;

  logic [31:0] s0, s1, s2, rv0, rv1;
  logic [4:0]  rn0, rn1;
  logic        ren0, ren1;

  assign stage_result = {s2, s1, s0};
  assign read_number  = {rn1, rn0};
  assign read_enable  = {ren1, ren0};
  assign read_value   = {rv1, rv0};

  always #5 clock = ~clock;

  hazard_forward_tracker #(.XLEN(XLEN), .STAGES(STAGES), .READ_PORTS(RP)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rd_enable(issue_rd_enable),
    .hold(hold), .flush(flush),
    .stage_result_valid(srv), .stage_result(stage_result),
    .read_enable(read_enable), .read_number(read_number), .read_value(read_value),
    .read_result(read_result), .read_pending(read_pending),
    .stall_count(stall_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [1:0]  pend;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] stall_exp = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                      input logic [1:0] pend, input logic rdy);
    exp_t e;
    e.tag = tag; e.r0 = r0; e.r1 = r1; e.pend = pend; e.rdy = rdy;
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    chk({e.tag, ".r0"},    read_result[31:0],          e.r0);
    chk({e.tag, ".r1"},    read_result[63:32],         e.r1);
    chk({e.tag, ".pend"},  {30'd0, read_pending},      {30'd0, e.pend});
    chk({e.tag, ".rdy"},   {31'd0, issue_ready},       {31'd0, e.rdy});
    chk({e.tag, ".stall"}, stall_count,                stall_exp);
    @(posedge clock);
`ifdef FORWARD_STALL_COUNTER_EN
    if (reset) stall_exp = 32'd0;
    else if (issue_valid && (e.pend != 2'b00) && !hold && (stall_exp != 32'hFFFF_FFFF))
      stall_exp = stall_exp + 32'd1;
`endif
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rd_enable = 1'b0;
    hold = 1'b0; flush = 1'b0; srv = '0;
    s0 = 32'd0; s1 = 32'd0; s2 = 32'd0;
    rn0 = 5'd0; rn1 = 5'd0; ren0 = 1'b0; ren1 = 1'b0;
    rv0 = 32'h100; rv1 = 32'h200;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd; issue_rd_enable = 1'b1;
  endtask

  task automatic drain();
    repeat (STAGES) begin
      idle();
      step("drain", 32'h100, 32'h200, 2'b00, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clock); #1;
    step("rst", 32'h100, 32'h200, 2'b00, 1'b1);
    reset = 1'b0;

    // Single-cycle producer forwarded the cycle its result appears
    idle(); issue(5'd5); step("t1_issue", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); srv = 3'b001; s0 = 32'h11; rn0 = 5'd5; ren0 = 1'b1; rv0 = 32'h55;
    step("t1_fwd", 32'h11, 32'h200, 2'b00, 1'b1);
    idle(); rn0 = 5'd5; ren0 = 1'b1; rv0 = 32'h55; step("t1_e1", 32'h11, 32'h200, 2'b00, 1'b1);
    idle(); rn0 = 5'd5; ren0 = 1'b1; rv0 = 32'h55; step("t1_e2", 32'h11, 32'h200, 2'b00, 1'b1);
    idle(); rn0 = 5'd5; ren0 = 1'b1; rv0 = 32'h55; step("t1_ret", 32'h55, 32'h200, 2'b00, 1'b1);

    // Load-use stall for two cycles, then late result releases it
    idle(); issue(5'd7); step("t2_issue", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); issue(5'd8); rn0 = 5'd7; ren0 = 1'b1; step("t2_stall0", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); issue(5'd8); rn0 = 5'd7; ren0 = 1'b1; step("t2_stall1", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); issue(5'd8); rn0 = 5'd7; ren0 = 1'b1; srv = 3'b100; s2 = 32'hAB;
    step("t2_fwd", 32'hAB, 32'h200, 2'b00, 1'b1);
    drain();

    // Same rd in entries 0 and 2: youngest wins
    idle(); issue(5'd3); step("t3_a", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); issue(5'd4); step("t3_b", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); issue(5'd3); step("t3_c", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); srv = 3'b111; s0 = 32'h1; s1 = 32'h44; s2 = 32'h2;
    rn0 = 5'd3; ren0 = 1'b1; rn1 = 5'd4; ren1 = 1'b1;
    step("t3_young", 32'h1, 32'h44, 2'b00, 1'b1);
    drain();

    // x0 is never tracked or forwarded
    idle(); issue(5'd0); step("t4_issue0", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); srv = 3'b001; s0 = 32'hDEAD; rn0 = 5'd0; ren0 = 1'b1; rv0 = 32'h0;
    step("t4_x0", 32'h0, 32'h200, 2'b00, 1'b1);
    drain();

    // Hold keeps position and captures a pulsed result
    idle(); issue(5'd10); step("t5_issue", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); step("t5_b", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); hold = 1'b1; srv = 3'b010; s1 = 32'hCAFE; rn0 = 5'd10; ren0 = 1'b1;
    step("t5_h0", 32'hCAFE, 32'h200, 2'b00, 1'b0);
    idle(); hold = 1'b1; rn0 = 5'd10; ren0 = 1'b1; step("t5_h1", 32'hCAFE, 32'h200, 2'b00, 1'b0);
    idle(); hold = 1'b1; rn0 = 5'd10; ren0 = 1'b1; step("t5_h2", 32'hCAFE, 32'h200, 2'b00, 1'b0);
    idle(); rn0 = 5'd10; ren0 = 1'b1; step("t5_rel", 32'hCAFE, 32'h200, 2'b00, 1'b1);
    idle(); rn0 = 5'd10; ren0 = 1'b1; step("t5_e2", 32'hCAFE, 32'h200, 2'b00, 1'b1);
    drain();

    // Flush without and with hold
    idle(); issue(5'd9); step("t6_issue", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); flush = 1'b1; rn0 = 5'd9; ren0 = 1'b1; rv0 = 32'h99;
    step("t6_flush", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); rn0 = 5'd9; ren0 = 1'b1; rv0 = 32'h99; step("t6_after", 32'h99, 32'h200, 2'b00, 1'b1);
    idle(); issue(5'd9); step("t6_issue2", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); hold = 1'b1; flush = 1'b1; rn0 = 5'd9; ren0 = 1'b1; rv0 = 32'h99;
    step("t6_hflush", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); rn0 = 5'd9; ren0 = 1'b1; rv0 = 32'h99; step("t6_hafter", 32'h99, 32'h200, 2'b00, 1'b1);

    // Reset in the middle of a stall
    idle(); issue(5'd12); step("t7_issue", 32'h100, 32'h200, 2'b00, 1'b1);
    idle(); issue(5'd13); rn0 = 5'd12; ren0 = 1'b1; step("t7_s0", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); issue(5'd13); rn0 = 5'd12; ren0 = 1'b1; step("t7_s1", 32'h0, 32'h200, 2'b01, 1'b0);
    idle(); issue(5'd13); rn0 = 5'd12; ren0 = 1'b1; reset = 1'b1;
    step("t7_rst", 32'h0, 32'h200, 2'b01, 1'b0);
    reset = 1'b0;
    idle(); issue(5'd13); rn0 = 5'd12; ren0 = 1'b1; step("t7_post", 32'h100, 32'h200, 2'b00, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
